// File: rtl/dcache_nway_wb.sv
// dcache_nway_wb
// N-way set-associative, write-back, write-allocate data cache between the
// LSU and the memory/AXI bridge. A request is accepted in IDLE, looked up in
// LOOKUP and answered with a one-cycle cpu_resp_valid pulse. A miss picks a
// victim (lowest invalid way, else the per-set round-robin pointer), writes it
// back if dirty, refills the line and replays the lookup.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   cpu_req_valid/_ready     CPU request handshake (ready only in IDLE)
//   cpu_req_we               1 = store, 0 = load
//   cpu_addr                 byte address, bits [1:0] ignored
//   cpu_wdata, cpu_wstrb     store data and byte enables
//   cpu_resp_valid           one-cycle completion pulse for loads and stores
//   cpu_rdata                load data, valid with cpu_resp_valid
//   mem_req_valid/_ready     memory request handshake
//   mem_req_we               1 = line writeback, 0 = line read
//   mem_req_addr             line-aligned address
//   mem_req_wline            writeback line, word 0 in bits [31:0]
//   mem_resp_valid/_line     refill line delivery
//   hit_cnt, miss_cnt        wrapping hit and miss counters
module dcache_nway_wb #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req_valid,
  input  logic                    cpu_req_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic [3:0]              cpu_wstrb,
  output logic                    cpu_req_ready,
  output logic                    cpu_resp_valid,
  output logic [31:0]             cpu_rdata,
  output logic                    mem_req_valid,
  output logic                    mem_req_we,
  output logic [ADDR_W-1:0]       mem_req_addr,
  output logic [32*LINE_WORDS-1:0] mem_req_wline,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_resp_line,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = 32 * LINE_WORDS;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, RF_REQ, RF_WAIT} state_t;

  state_t state, state_next;

  // Cache storage
  logic [TAG_W-1:0]  tag_mem   [WAYS][SETS];
  logic [LINE_W-1:0] data_mem  [WAYS][SETS];
  logic              valid_mem [WAYS][SETS];
  logic              dirty_mem [WAYS][SETS];

  // Latched request
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic              req_we;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic [WAY_W-1:0]  victim;
  // Set after a refill so the replayed lookup is not counted as a hit
  logic              replay;

  // Lookup results
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  miss_way;
  logic [WAY_W-1:0]  rr_cur;
  logic              rr_adv;
  logic [LINE_W-1:0] hit_line;
  logic [31:0]       hit_word;

  logic addr_lsb_unused;
  assign addr_lsb_unused = ^cpu_addr[1:0];

  // Tag compare across all ways and victim choice. The invalid-way scan runs
  // from the top down so the lowest-index invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[w][req_idx]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    miss_way = inv_found ? inv_way : rr_cur;
    rr_adv   = (state == LOOKUP) && !hit && !inv_found;
    hit_line = data_mem[hit_way][req_idx];
    hit_word = hit_line[{req_word, 5'b00000} +: 32];
  end

  // Round-robin pointer per set; only advanced when a valid line is evicted.
  generate
    if (WAYS > 1) begin : g_rr
      logic [WAY_W-1:0] rr_ptr [SETS];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else if (rr_adv) begin
          rr_ptr[req_idx] <= rr_ptr[req_idx] + 1'b1;
        end
      end
      assign rr_cur = rr_ptr[req_idx];
    end else begin : g_dm
      logic rr_unused;
      assign rr_unused = rr_adv;
      assign rr_cur    = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and handshake outputs. Writeback address and data come from
  // the registered victim, which cannot change while waiting in WB_REQ.
  always_comb begin
    state_next    = state;
    cpu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wline = '0;
    case (state)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (hit)
          state_next = IDLE;
        else if (valid_mem[miss_way][req_idx] && dirty_mem[miss_way][req_idx])
          state_next = WB_REQ;
        else
          state_next = RF_REQ;
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {tag_mem[victim][req_idx], req_idx, {OFF_W{1'b0}}};
        mem_req_wline = data_mem[victim][req_idx];
        if (mem_req_ready) state_next = RF_REQ;
      end
      RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (mem_req_ready) state_next = RF_WAIT;
      end
      RF_WAIT: begin
        if (mem_resp_valid) state_next = LOOKUP;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line data and tags carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == LOOKUP && hit && req_we) begin
        for (int b = 0; b < 4; b++) begin
          if (req_wstrb[b])
            data_mem[hit_way][req_idx][{req_word, 2'(b), 3'b000} +: 8] <= req_wdata[8*b +: 8];
        end
      end
      if (state == RF_WAIT && mem_resp_valid) begin
        data_mem[victim][req_idx] <= mem_resp_line;
        tag_mem[victim][req_idx]  <= req_tag;
      end
    end
  end

  // Request latch, line state bits, response and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_mem[w][s] <= 1'b0;
          dirty_mem[w][s] <= 1'b0;
        end
      end
      req_tag        <= '0;
      req_idx        <= '0;
      req_word       <= '0;
      req_we         <= 1'b0;
      req_wdata      <= '0;
      req_wstrb      <= '0;
      victim         <= '0;
      replay         <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      hit_cnt        <= '0;
      miss_cnt       <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            req_tag   <= cpu_addr[ADDR_W-1 -: TAG_W];
            req_idx   <= cpu_addr[OFF_W +: IDX_W];
            req_word  <= cpu_addr[2 +: WORD_W];
            req_we    <= cpu_req_we;
            req_wdata <= cpu_wdata;
            req_wstrb <= cpu_wstrb;
            replay    <= 1'b0;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_resp_valid <= 1'b1;
            if (req_we) dirty_mem[hit_way][req_idx] <= 1'b1;
            else        cpu_rdata <= hit_word;
            if (!replay) hit_cnt <= hit_cnt + 32'd1;
          end else begin
            miss_cnt <= miss_cnt + 32'd1;
            victim   <= miss_way;
          end
        end
        RF_WAIT: begin
          if (mem_resp_valid) begin
            valid_mem[victim][req_idx] <= 1'b1;
            dirty_mem[victim][req_idx] <= 1'b0;
            replay                     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_nway_wb.sv
// Testbench for dcache_nway_wb (default parameters). A reference model keeps
// per-way line contents, valid/dirty flags and a round-robin pointer per set
// plus its own copy of backing memory; each request predicts hit/miss,
// writeback, refill address and load data. A memory responder process serves
// line requests with optional stall cycles.
module tb_dcache_nway_wb;

  localparam int WAYS = 2;
  localparam int SETS = 64;

  logic         clk;
  logic         rst;
  logic         cpu_req_valid;
  logic         cpu_req_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_wstrb;
  logic         cpu_req_ready;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_rdata;
  logic         mem_req_valid;
  logic         mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [255:0] mem_req_wline;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [255:0] mem_resp_line;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  dcache_nway_wb dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_req_ready(cpu_req_ready),
    .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wline(mem_req_wline), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_line(mem_resp_line),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] defLine();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'h000000A0 + 32'(i);
    return l;
  endfunction

  // ---------------- memory responder ----------------
  logic [255:0] mem_lines [logic [31:0]];
  logic [31:0]  wb_q  [$];
  logic [255:0] wbl_q [$];
  logic [31:0]  rf_q  [$];
  int           stall_left = 0;
  bit           hold_resp  = 0;
  bit           pending    = 0;
  logic [31:0]  pending_addr;
  bit           cap_valid  = 0;
  logic [31:0]  cap_addr;
  logic [255:0] cap_line;
  logic         cap_we;

  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_line  = '0;
    forever begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (rst) begin
        pending   = 0;
        cap_valid = 0;
      end else if (pending) begin
        if (!hold_resp) begin
          mem_resp_valid = 1'b1;
          mem_resp_line  = mem_lines.exists(pending_addr) ? mem_lines[pending_addr] : defLine();
          pending        = 0;
        end
      end else if (mem_req_valid || cap_valid) begin
        if (cap_valid) begin
          checkOutput("stall_valid", mem_req_valid, 1'b1);
          checkOutput("stall_we", mem_req_we, cap_we);
          checkOutput("stall_addr", mem_req_addr, cap_addr);
          checkOutput("stall_wline", mem_req_wline, cap_line);
          checkOutput("stall_cpu_ready", cpu_req_ready, 1'b0);
        end
        if (stall_left > 0) begin
          if (!cap_valid) begin
            cap_valid = 1;
            cap_addr  = mem_req_addr;
            cap_line  = mem_req_wline;
            cap_we    = mem_req_we;
          end
          stall_left--;
        end else if (mem_req_valid) begin
          cap_valid     = 0;
          mem_req_ready = 1'b1;
          if (mem_req_we) begin
            mem_lines[mem_req_addr] = mem_req_wline;
            wb_q.push_back(mem_req_addr);
            wbl_q.push_back(mem_req_wline);
          end else begin
            rf_q.push_back(mem_req_addr);
            pending      = 1;
            pending_addr = mem_req_addr;
          end
        end else begin
          cap_valid = 0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic         m_valid [WAYS][SETS];
  logic         m_dirty [WAYS][SETS];
  logic [20:0]  m_tag   [WAYS][SETS];
  logic [255:0] m_data  [WAYS][SETS];
  int           m_rr    [SETS];
  logic [255:0] ref_mem [logic [31:0]];
  int           exp_hits;
  int           exp_misses;

  task automatic modelReset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
    for (int s = 0; s < SETS; s++) m_rr[s] = 0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic modelAccess(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, output bit hit, output bit wb,
                             output logic [31:0] wb_addr, output logic [255:0] wb_line,
                             output logic [31:0] rf_addr, output logic [31:0] rdata);
    logic [20:0] tag;
    int idx, wd, way;
    tag = addr[31:11];
    idx = int'(addr[10:5]);
    wd  = int'(addr[4:2]);
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[w][idx] && m_tag[w][idx] == tag) way = w;
    hit = (way >= 0);
    wb = 0; wb_addr = '0; wb_line = '0; rf_addr = '0; rdata = '0;
    if (hit) begin
      exp_hits++;
    end else begin
      exp_misses++;
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[w][idx]) way = w;
      if (way < 0) begin
        way = m_rr[idx];
        m_rr[idx] = (m_rr[idx] + 1) % WAYS;
      end
      if (m_valid[way][idx] && m_dirty[way][idx]) begin
        wb      = 1;
        wb_addr = {m_tag[way][idx], idx[5:0], 5'b00000};
        wb_line = m_data[way][idx];
        ref_mem[wb_addr] = wb_line;
      end
      rf_addr = {tag, idx[5:0], 5'b00000};
      m_data[way][idx]  = ref_mem.exists(rf_addr) ? ref_mem[rf_addr] : defLine();
      m_tag[way][idx]   = tag;
      m_valid[way][idx] = 1'b1;
      m_dirty[way][idx] = 1'b0;
    end
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) m_data[way][idx][wd*32 + b*8 +: 8] = wdata[b*8 +: 8];
      m_dirty[way][idx] = 1'b1;
    end else begin
      rdata = m_data[way][idx][wd*32 +: 32];
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb);
    bit hit, wb, done;
    logic [31:0] wb_addr, rf_addr, rdata;
    logic [255:0] wb_line;
    int cycles;
    modelAccess(we, addr, wdata, wstrb, hit, wb, wb_addr, wb_line, rf_addr, rdata);
    wb_q.delete();
    wbl_q.delete();
    rf_q.delete();
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_addr      = addr;
    cpu_wdata     = wdata;
    cpu_wstrb     = wstrb;
    checkOutput("req_ready", cpu_req_ready, 1'b1);
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    cycles = 0;
    done   = 0;
    while (!done && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cpu_resp_valid) done = 1;
    end
    checkOutput("resp_seen", done, 1'b1);
    if (hit) checkOutput("hit_latency", cycles, 1);
    if (!we) checkOutput("rdata", cpu_rdata, rdata);
    checkOutput("hit_cnt", hit_cnt, exp_hits);
    checkOutput("miss_cnt", miss_cnt, exp_misses);
    checkOutput("wb_count", wb_q.size(), wb ? 1 : 0);
    checkOutput("rf_count", rf_q.size(), hit ? 0 : 1);
    if (wb && wb_q.size() > 0) begin
      checkOutput("wb_addr", wb_q[0], wb_addr);
      checkOutput("wb_line", wbl_q[0], wb_line);
    end
    if (!hit && rf_q.size() > 0) checkOutput("rf_addr", rf_q[0], rf_addr);
    @(posedge clk);
    #1;
    checkOutput("resp_pulse", cpu_resp_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    bit seen;
    rst = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    cpu_wstrb = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", cpu_req_ready, 1'b1);
    checkOutput("rst_resp_valid", cpu_resp_valid, 1'b0);
    checkOutput("rst_rdata", cpu_rdata, 32'h0);
    checkOutput("rst_mem_valid", mem_req_valid, 1'b0);
    checkOutput("rst_hit_cnt", hit_cnt, 32'h0);
    checkOutput("rst_miss_cnt", miss_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed sequence from the basic scenarios
    applyStimulus(1'b0, 32'h44, 32'h0, 4'h0);
    checkOutput("first_rdata", cpu_rdata, 32'h000000A1);
    applyStimulus(1'b0, 32'h44, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h44, 32'hDEADBEEF, 4'b0011);
    applyStimulus(1'b0, 32'h44, 32'h0, 4'h0);
    checkOutput("merged_rdata", cpu_rdata, 32'h0000BEEF);
    applyStimulus(1'b0, 32'h840, 32'h0, 4'h0);
    applyStimulus(1'b0, 32'h1040, 32'h0, 4'h0);
    checkOutput("evict_wb_word1", (wbl_q.size() > 0) ? wbl_q[0][63:32] : 32'h0, 32'h0000BEEF);
    applyStimulus(1'b0, 32'h1840, 32'h0, 4'h0);

    // Dirty the line in way0 and hold the writeback off for 5 cycles
    applyStimulus(1'b1, 32'h1048, 32'h12345678, 4'b1111);
    stall_left = 5;
    applyStimulus(1'b0, 32'h2040, 32'h0, 4'h0);

    // Randomised traffic over a few sets and tags
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      int sel;
      sel = int'($urandom_range(0, 2));
      a = ($urandom_range(0, 4) << 11) |
          (((sel == 0) ? 32'd2 : (sel == 1) ? 32'd3 : 32'd7) << 5) |
          ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      stall_left = int'($urandom_range(0, 2));
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    // Reset while waiting for a refill in an otherwise unused set
    stall_left = 0;
    hold_resp  = 1;
    rf_q.delete();
    wb_q.delete();
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_addr      = 32'h0007F280;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    seen = 0;
    cnt  = 0;
    while (!seen && cnt < 50) begin
      @(negedge clk);
      cnt++;
      if (rf_q.size() > 0) seen = 1;
    end
    checkOutput("rf_reached", seen, 1'b1);
    checkOutput("rf_no_wb", wb_q.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_mem_valid", mem_req_valid, 1'b0);
    checkOutput("midrst_ready", cpu_req_ready, 1'b1);
    checkOutput("midrst_hit_cnt", hit_cnt, 32'h0);
    checkOutput("midrst_miss_cnt", miss_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    hold_resp = 0;
    modelReset();
    applyStimulus(1'b0, 32'h44, 32'h0, 4'h0);
    checkOutput("post_rst_miss", miss_cnt, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
